// File: rtl/stopwatch_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : stopwatch_counter
// Description : MM:SS BCD stopwatch core with run/pause, clear and field adjust.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_counter #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_TENS    = 5
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       clk_1hz_in,
    input  logic       clk_2hz_in,
    input  logic       clk_blink_in,
    input  logic       btn_pause,
    input  logic       btn_clear,
    input  logic       sw_adj,
    input  logic       sw_sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] blank,
    output logic       running,
    output logic       wrap
);

    localparam logic [1:0] c_ST_RUN     = 2'd0;
    localparam logic [1:0] c_ST_PAUSED  = 2'd1;
    localparam logic [1:0] c_ST_ADJUST  = 2'd2;
    localparam logic [3:0] c_TENS_MAX   = 4'(MAX_TENS);
    localparam logic [7:0] c_FIELD_TERM = {c_TENS_MAX, 4'd9};

    logic [3:0] w_async;
    logic [3:0] w_sync;
    logic [1:0] r_btn_d;
    logic       w_pause_pulse;
    logic       w_clear_pulse;
    logic       w_adj;
    logic       w_sel;

    logic [1:0] r_cur;
    logic [1:0] r_prev;
    logic       r_blink_cur;
    logic       r_arm;
    logic [1:0] w_tick;

    logic [1:0] r_state;
    logic [1:0] r_saved;
    logic [7:0] r_min;
    logic [7:0] r_sec;
    logic [3:0] r_blank;
    logic       r_running;
    logic       r_wrap;

    logic [1:0] w_state_nxt;
    logic [1:0] w_saved_nxt;
    logic [7:0] w_min_nxt;
    logic [7:0] w_sec_nxt;
    logic [3:0] w_blank_nxt;
    logic       w_wrap_nxt;

    assign w_async = {sw_sel, sw_adj, btn_clear, btn_pause};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] r_chain;
            always_ff @(posedge clock_in or negedge reset_n) begin
                if (!reset_n) begin
                    r_chain <= '0;
                end else begin
                    r_chain <= {r_chain[SYNC_STAGES-2:0], w_async[gi]};
                end
            end
            assign w_sync[gi] = r_chain[SYNC_STAGES-1];
        end
    endgenerate

    assign w_pause_pulse = w_sync[0] & ~r_btn_d[0];
    assign w_clear_pulse = w_sync[1] & ~r_btn_d[1];
    assign w_adj         = w_sync[2];
    assign w_sel         = w_sync[3];

    // Before arming, prev is loaded with the live level so the level present
    // at reset release can never look like a transition.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_btn_d     <= 2'b00;
            r_cur       <= 2'b00;
            r_prev      <= 2'b00;
            r_blink_cur <= 1'b0;
            r_arm       <= 1'b0;
        end else begin
            r_btn_d     <= w_sync[1:0];
            r_cur       <= {clk_2hz_in, clk_1hz_in};
            r_prev      <= r_arm ? r_cur : {clk_2hz_in, clk_1hz_in};
            r_blink_cur <= clk_blink_in;
            r_arm       <= 1'b1;
        end
    end

    assign w_tick = r_arm ? (r_cur ^ r_prev) : 2'b00;

    function automatic logic [7:0] f_field_inc(input logic [7:0] field);
        logic [7:0] v;
        if (field[3:0] == 4'd9) begin
            v[3:0] = 4'd0;
            v[7:4] = (field[7:4] == c_TENS_MAX) ? 4'd0 : field[7:4] + 4'd1;
        end else begin
            v = {field[7:4], field[3:0] + 4'd1};
        end
        return v;
    endfunction

    // Priority: clear, then any state transition, then a tick increment.
    always_comb begin
        w_state_nxt = r_state;
        w_saved_nxt = r_saved;
        w_min_nxt   = r_min;
        w_sec_nxt   = r_sec;
        w_wrap_nxt  = 1'b0;
        if (w_clear_pulse) begin
            w_min_nxt = 8'h00;
            w_sec_nxt = 8'h00;
        end else if ((r_state != c_ST_ADJUST) && w_adj) begin
            w_saved_nxt = r_state;
            w_state_nxt = c_ST_ADJUST;
        end else if ((r_state == c_ST_ADJUST) && !w_adj) begin
            w_state_nxt = r_saved;
        end else if ((r_state != c_ST_ADJUST) && w_pause_pulse) begin
            w_state_nxt = (r_state == c_ST_RUN) ? c_ST_PAUSED : c_ST_RUN;
        end else if ((r_state == c_ST_RUN) && w_tick[0]) begin
            w_sec_nxt = f_field_inc(r_sec);
            if (r_sec == c_FIELD_TERM) begin
                w_min_nxt  = f_field_inc(r_min);
                w_wrap_nxt = (r_min == c_FIELD_TERM);
            end
        end else if ((r_state == c_ST_ADJUST) && w_tick[1]) begin
            if (w_sel) begin
                w_sec_nxt = f_field_inc(r_sec);
            end else begin
                w_min_nxt = f_field_inc(r_min);
            end
        end
    end

    always_comb begin
        w_blank_nxt = 4'b0000;
        if ((w_state_nxt == c_ST_ADJUST) && r_blink_cur) begin
            w_blank_nxt = w_sel ? 4'b0011 : 4'b1100;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= c_ST_RUN;
            r_saved   <= c_ST_RUN;
            r_min     <= 8'h00;
            r_sec     <= 8'h00;
            r_blank   <= 4'b0000;
            r_running <= 1'b1;
            r_wrap    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_saved   <= w_saved_nxt;
            r_min     <= w_min_nxt;
            r_sec     <= w_sec_nxt;
            r_blank   <= w_blank_nxt;
            r_running <= (w_state_nxt == c_ST_RUN);
            r_wrap    <= w_wrap_nxt;
        end
    end

    assign min_tens = r_min[7:4];
    assign min_ones = r_min[3:0];
    assign sec_tens = r_sec[7:4];
    assign sec_ones = r_sec[3:0];
    assign blank    = r_blank;
    assign running  = r_running;
    assign wrap     = r_wrap;

endmodule
`default_nettype wire
